// File: rtl/lap_recorder.sv
// Lap recorder: captures the live seconds digits on each debounced lap press
// into a small write-once buffer and lets the user step through the stored
// entries with the view button.

// Two-flop synchronizer followed by a level debouncer. The output is a single
// cycle pulse on each accepted press (stable level falling 1 -> 0).
module lap_debounce #(
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic i_clock,
   input  logic i_clear_b,
   input  logic i_btn_n,
   output logic o_press_p
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic          r_sync1;
   logic          r_sync2;
   logic          r_stable;
   logic          r_pulse;
   logic [CW-1:0] r_cnt;
   logic          w_diff;
   logic          w_done;

   assign w_diff = (r_sync2 != r_stable);
   // The sample that completes the run of mismatching cycles flips the level.
   assign w_done = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

   // Synchronize, count consecutive mismatches, accept the level and pulse on press.
   always_ff @(posedge i_clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values of the others (sync1 -> sync2 is a real stage).
      if (i_clear_b) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_stable <= 1'b1;
         r_cnt    <= '0;
         r_pulse  <= 1'b0;
      end else begin
         r_sync1 <= i_btn_n;
         r_sync2 <= r_sync1;
         r_pulse <= w_done && r_stable;
         if (w_done) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else if (w_diff) begin
            r_cnt <= r_cnt + CW'(1);
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_press_p = r_pulse;

endmodule

module lap_recorder #(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int DEPTH           = 4
) (
   input  logic                       i_clock,
   input  logic                       i_clear_b,
   input  logic [3:0]                 i_ones,
   input  logic [3:0]                 i_tens,
   input  logic                       i_lap_n,
   input  logic                       i_view_n,
   output logic [3:0]                 o_disp_ones,
   output logic [3:0]                 o_disp_tens,
   output logic                       o_reviewing,
   output logic [$clog2(DEPTH)-1:0]   o_slot,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {
      LIVE   = 1'b0,
      REVIEW = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [PW-1:0] r_slot;
   logic [PW-1:0] w_slot_nxt;
   logic [CW-1:0] r_count;
   logic          r_overflow;
   logic [7:0]    r_mem [DEPTH];
   logic [7:0]    r_view;
   logic          w_lap_p;
   logic          w_view_p;
   logic          w_full;
   logic [PW-1:0] w_wptr;

   lap_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap_db (
      .i_clock   (i_clock),
      .i_clear_b (i_clear_b),
      .i_btn_n   (i_lap_n),
      .o_press_p (w_lap_p)
   );

   lap_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_view_db (
      .i_clock   (i_clock),
      .i_clear_b (i_clear_b),
      .i_btn_n   (i_view_n),
      .o_press_p (w_view_p)
   );

   assign w_full = (r_count == CW'(DEPTH));
   // The buffer never wraps, so the next free slot is always the entry count.
   assign w_wptr = r_count[PW-1:0];

   // Track the number of stored entries and the sticky dropped-lap flag.
   always_ff @(posedge i_clock) begin
      if (i_clear_b) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (w_lap_p) begin
         if (w_full) begin
            r_overflow <= 1'b1;
         end else begin
            r_count <= r_count + CW'(1);
         end
      end
   end

   // Store the live digits at the write pointer on an accepted lap press.
   always_ff @(posedge i_clock) begin
      // NOTE: the entry storage has no reset; entries at or above r_count are
      // never displayed, so clearing them would only cost logic.
      if (!i_clear_b && w_lap_p && !w_full) begin
         r_mem[w_wptr] <= {i_tens, i_ones};
      end
   end

   // State and slot registers for the view FSM.
   always_ff @(posedge i_clock) begin
      if (i_clear_b) begin
         r_state <= LIVE;
         r_slot  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_slot  <= w_slot_nxt;
      end
   end

   // Next-state logic; the view decision uses the count before any same-cycle capture.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      w_state_nxt = r_state;
      w_slot_nxt  = r_slot;
      if (w_view_p) begin
         case (r_state)
            LIVE: begin
               if (r_count != '0) begin
                  w_state_nxt = REVIEW;
                  w_slot_nxt  = '0;
               end
            end
            REVIEW: begin
               if ((32'(r_slot) + 32'd1) < 32'(r_count)) begin
                  w_slot_nxt = r_slot + PW'(1);
               end else begin
                  w_state_nxt = LIVE;
                  w_slot_nxt  = '0;
               end
            end
            default: begin
               w_state_nxt = LIVE;
               w_slot_nxt  = '0;
            end
         endcase
      end
   end

   // Registered copy of the entry being reviewed, following the next slot.
   always_ff @(posedge i_clock) begin
      r_view <= r_mem[w_slot_nxt];
   end

   assign o_disp_tens = (r_state == REVIEW) ? r_view[7:4] : i_tens;
   assign o_disp_ones = (r_state == REVIEW) ? r_view[3:0] : i_ones;
   assign o_reviewing = (r_state == REVIEW);
   assign o_slot      = r_slot;
   assign o_count     = r_count;
   assign o_overflow  = r_overflow;

endmodule
